// File: rtl/q3_window_feeder.sv
// Feeds the 2014_q3 window-check FSM: buffers 3-bit windows from a valid/ready producer
// and streams them LSB-first on w after a one-cycle s strobe, zero-padding on underrun.
module q3_window_feeder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [2:0]                 in_data,
  output logic                       in_ready,
  output logic                       s,
  output logic                       w,
  output logic                       busy,
  output logic                       underrun,
  output logic [CNT_W-1:0]           win_count,
  output logic [CNT_W-1:0]           pad_count,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t           state_r, state_nx_s;
  logic [1:0]       phase_r, phase_nx_s;
  logic [2:0]       win_r, win_nx_s;
  logic [2:0]       mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [AW:0]      level_r, level_nx_s;
  logic             in_ready_r, s_r, w_r, busy_r, underrun_r;
  logic [CNT_W-1:0] win_count_r, pad_count_r;
  logic             push_s, load_s, pop_s, pad_s, w_nx_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Load edges enter phase 0; the head window is taken if present, otherwise zeros go out.
  always_comb begin
    push_s     = in_valid && in_ready_r;
    load_s     = (state_r == START) || ((state_r == STREAM) && (phase_r == 2'd2));
    pop_s      = load_s && (level_r != {(AW+1){1'b0}});
    pad_s      = load_s && (level_r == {(AW+1){1'b0}});
    state_nx_s = state_r;
    phase_nx_s = phase_r;
    win_nx_s   = win_r;
    level_nx_s = level_r;

    case ({push_s, pop_s})
      2'b10:   level_nx_s = level_r + {{AW{1'b0}}, 1'b1};
      2'b01:   level_nx_s = level_r - {{AW{1'b0}}, 1'b1};
      default: level_nx_s = level_r;
    endcase

    case (state_r)
      IDLE: begin
        if (start && (level_r != {(AW+1){1'b0}})) begin
          state_nx_s = START;
        end else begin
          state_nx_s = IDLE;
        end
      end
      START: begin
        state_nx_s = STREAM;
        phase_nx_s = 2'd0;
      end
      STREAM: begin
        if (phase_r == 2'd2) begin
          phase_nx_s = 2'd0;
        end else begin
          phase_nx_s = phase_r + 2'd1;
        end
      end
      default: begin
        state_nx_s = IDLE;
        phase_nx_s = 2'd0;
      end
    endcase

    if (pop_s) begin
      win_nx_s = mem_r[rd_ptr_r];
    end else if (pad_s) begin
      win_nx_s = 3'b000;
    end else begin
      win_nx_s = win_r;
    end

    if (state_nx_s == STREAM) begin
      w_nx_s = win_nx_s[phase_nx_s];
    end else begin
      w_nx_s = 1'b0;
    end
  end

  // FIFO storage; entries need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Control state, pointers, counters and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      phase_r     <= 2'd0;
      win_r       <= 3'b000;
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      level_r     <= {(AW+1){1'b0}};
      in_ready_r  <= 1'b1;
      s_r         <= 1'b0;
      w_r         <= 1'b0;
      busy_r      <= 1'b0;
      underrun_r  <= 1'b0;
      win_count_r <= {CNT_W{1'b0}};
      pad_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_nx_s;
      phase_r    <= phase_nx_s;
      win_r      <= win_nx_s;
      level_r    <= level_nx_s;
      in_ready_r <= (level_nx_s != FULL_LVL);
      s_r        <= (state_nx_s == START);
      w_r        <= w_nx_s;
      busy_r     <= (state_nx_s != IDLE);
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (load_s) begin
        win_count_r <= sat_inc(win_count_r);
      end
      if (pad_s) begin
        pad_count_r <= sat_inc(pad_count_r);
        underrun_r  <= 1'b1;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign s         = s_r;
  assign w         = w_r;
  assign busy      = busy_r;
  assign underrun  = underrun_r;
  assign win_count = win_count_r;
  assign pad_count = pad_count_r;
  assign level     = level_r;

endmodule

// File: tb/tb_q3_window_feeder.sv
// Self-checking bench for q3_window_feeder: fill table plus directed sequences, with a
// queue of expected w bits pushed as windows are driven and popped as bits stream out.
module tb_q3_window_feeder;

  logic       clk = 1'b0;
  logic       reset, start, in_valid;
  logic [2:0] in_data;
  logic       in_ready, s, w, busy, underrun;
  logic [3:0] win_count, pad_count;
  logic [2:0] level;

  int   n_chk  = 0;
  int   n_fail = 0;
  logic exp_q[$];

  q3_window_feeder #(.DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .s(s), .w(w), .busy(busy), .underrun(underrun),
    .win_count(win_count), .pad_count(pad_count), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] d;
    logic       acc;
    logic [2:0] lvl;
    logic       rdy;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_bits(input logic [2:0] d);
    exp_q.push_back(d[0]);
    exp_q.push_back(d[1]);
    exp_q.push_back(d[2]);
  endtask

  task automatic cmp_bit(input string name);
    logic e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: w=%0b but no expected bit queued", name, w);
    end else begin
      e = exp_q.pop_front();
      chk(name, w, e);
    end
  endtask

  task automatic stream_bit(input string name);
    tick();
    cmp_bit(name);
  endtask

  task automatic push(input logic [2:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    sb_bits(d);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 3'b000;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    vec_t       tbl[6];
    logic       acc;
    logic [2:0] d;

    do_reset();
    chk("rst_s", s, 1'b0);
    chk("rst_w", w, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_win_count", win_count, 4'd0);
    chk("rst_pad_count", pad_count, 4'd0);
    chk("rst_level", level, 3'd0);
    chk("rst_in_ready", in_ready, 1'b1);

    // 1: single window 110 streamed as 0,1,1
    push(3'b110);
    chk("t1_level", level, 3'd1);
    start = 1'b1;
    tick();
    chk("t1_s_high", s, 1'b1);
    chk("t1_w_in_start", w, 1'b0);
    start = 1'b0;
    stream_bit("t1_bit0");
    chk("t1_s_low", s, 1'b0);
    stream_bit("t1_bit1");
    stream_bit("t1_bit2");
    chk("t1_win_count", win_count, 4'd1);
    chk("t1_underrun", underrun, 1'b0);

    // 2: start ignored while empty; s two cycles after the push cycle; start held high
    do_reset();
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_s_idle", s, 1'b0);
      chk("t2_busy_idle", busy, 1'b0);
    end
    push(3'b001);
    chk("t2_s_after_push", s, 1'b0);
    tick();
    chk("t2_s_pulse", s, 1'b1);
    chk("t2_busy", busy, 1'b1);
    stream_bit("t2_bit0");
    chk("t2_s_once", s, 1'b0);
    stream_bit("t2_bit1");
    chk("t2_s_held_start", s, 1'b0);
    stream_bit("t2_bit2");

    // 3: underrun pads a zero window, late push goes out in the next slot
    do_reset();
    push(3'b011);
    start = 1'b1;
    tick();
    chk("t3_s", s, 1'b1);
    start = 1'b0;
    sb_bits(3'b000);
    for (int i = 0; i < 4; i++) stream_bit("t3_stream");
    chk("t3_underrun", underrun, 1'b1);
    chk("t3_pad_count", pad_count, 4'd1);
    chk("t3_win_count_pad", win_count, 4'd2);
    in_valid = 1'b1;
    in_data  = 3'b101;
    sb_bits(3'b101);
    stream_bit("t3_pad_bit1");
    in_valid = 1'b0;
    chk("t3_level_late", level, 3'd1);
    for (int i = 0; i < 4; i++) stream_bit("t3_stream_late");
    chk("t3_win_count", win_count, 4'd3);
    chk("t3_pad_count_end", pad_count, 4'd1);

    // 4: fill to full, then drain one window every three cycles
    do_reset();
    tbl[0] = '{1'b1, 3'b100, 1'b1, 3'd1, 1'b1};
    tbl[1] = '{1'b1, 3'b010, 1'b1, 3'd2, 1'b1};
    tbl[2] = '{1'b1, 3'b111, 1'b1, 3'd3, 1'b1};
    tbl[3] = '{1'b1, 3'b001, 1'b1, 3'd4, 1'b0};
    tbl[4] = '{1'b1, 3'b110, 1'b0, 3'd4, 1'b0};
    tbl[5] = '{1'b0, 3'b000, 1'b0, 3'd4, 1'b0};
    for (int i = 0; i < 6; i++) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      tick();
      if (tbl[i].acc) sb_bits(tbl[i].d);
      chk("t4_fill_level", level, tbl[i].lvl);
      chk("t4_fill_ready", in_ready, tbl[i].rdy);
    end
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    chk("t4_s", s, 1'b1);
    chk("t4_level_full", level, 3'd4);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 3; p++) begin
        stream_bit("t4_drain_bit");
        if (p == 0) begin
          chk("t4_drain_level", level, 3 - k);
          chk("t4_drain_ready", in_ready, 1'b1);
        end
      end
    end
    chk("t4_underrun", underrun, 1'b0);

    // 5: reset in phase 1 loses the window and the queued data
    do_reset();
    push(3'b110);
    push(3'b011);
    start = 1'b1;
    tick();
    start = 1'b0;
    stream_bit("t5_bit0");
    stream_bit("t5_bit1");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk("t5_s", s, 1'b0);
    chk("t5_w", w, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_level", level, 3'd0);
    chk("t5_win_count", win_count, 4'd0);
    chk("t5_pad_count", pad_count, 4'd0);
    chk("t5_in_ready", in_ready, 1'b1);
    push(3'b101);
    start = 1'b1;
    tick();
    chk("t5_restart_s", s, 1'b1);
    start = 1'b0;
    for (int i = 0; i < 3; i++) stream_bit("t5_new_bit");
    chk("t5_new_win_count", win_count, 4'd1);

    // 6: continuous producer, 1000 windows, counter saturation
    do_reset();
    in_valid = 1'b1;
    in_data  = 3'($urandom_range(0, 7));
    start    = 1'b1;
    for (int it = 0; it < 3002; it++) begin
      acc = in_ready;
      d   = in_data;
      tick();
      if (acc) begin
        sb_bits(d);
        in_data = 3'($urandom_range(0, 7));
      end
      if (it == 1) begin
        chk("t6_s", s, 1'b1);
      end else if (it >= 2) begin
        cmp_bit("t6_stream_bit");
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("t6_win_count_sat", win_count, 4'd15);
    chk("t6_pad_count", pad_count, 4'd0);
    chk("t6_underrun", underrun, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
